iob_eth_tx_framer: RTL and testbench
====================================

Name: iob_eth_tx_framer

Overview:
Ethernet transmit framer sitting directly upstream of iob_eth_crc and downstream of the TX buffer/DMA. Takes a payload byte stream (DA..data, no FCS) and emits a complete byte-wide frame to the PHY serializer:
- 7x 0x55 preamble, then 0xD5 SFD
- payload, then zero padding to the minimum length
- 4-byte FCS, then the inter-frame gap

It drives iob_eth_crc's start/data/enable inputs and consumes its crc output to build the FCS.

Parameters:
PAD_EN, 1, 1: pad payload+pad to MIN_LEN bytes; 0: no padding
MIN_LEN, 60, minimum payload+pad byte count (excludes FCS)
IFG_BYTES, 12, idle byte slots after each FCS
CNT_W, 11, width of payload byte counter (saturating)

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous active-high reset
tx_data_i  in  8  payload byte
tx_valid_i  in  1  payload byte valid
tx_last_i  in  1  marks final payload byte
tx_ready_o  out  1  payload byte accepted when tx_valid_i & tx_ready_o
phy_data_o  out  8  frame byte to PHY serializer
phy_valid_o  out  1  phy_data_o valid
phy_ready_i  in  1  serializer accepts byte this cycle (one byte slot)
crc_start_o  out  1  to iob_eth_crc start_i
crc_data_o  out  8  to iob_eth_crc data_i
crc_en_o  out  1  to iob_eth_crc data_en_i
crc_i  in  32  from iob_eth_crc crc_o
busy_o  out  1  high in any state except IDLE
frame_done_o  out  1  one-cycle pulse on transfer of last FCS byte

Behaviour:
- Reset is asynchronous and active-high. Reset state is IDLE, counters are 0. After reset: phy_valid_o=0, tx_ready_o=0, crc_en_o=0, busy_o=0, frame_done_o=0, crc_start_o=1.
- A "transfer" is phy_valid_o & phy_ready_i. All state and counter advances happen on transfers, except IDLE->PRE.
- IDLE:
  - crc_start_o=1 and phy_valid_o=0.
  - tx_valid_i=1 -> PRE on the next edge. The payload byte is not consumed.
- PRE: phy_data_o=0x55, phy_valid_o=1. After 7 transfers -> SFD.
- SFD: phy_data_o=0xD5. After 1 transfer -> PAY; byte counter cleared.
- PAY:
  - Combinational pass-through: phy_data_o=tx_data_i, phy_valid_o=tx_valid_i, tx_ready_o=phy_ready_i.
  - On each transfer: crc_en_o=1, crc_data_o=tx_data_i, byte counter increments (saturates at 2^CNT_W-1).
  - Transfer with tx_last_i=1: if PAD_EN and count+1 < MIN_LEN -> PAD, else -> FCS (FCS index 0).
  - tx_valid_i low mid-frame stalls the output (phy_valid_o=0). Underrun handling is the serializer's responsibility.
- PAD: phy_data_o=0x00, crc_data_o=0x00, crc_en_o on each transfer. When count reaches MIN_LEN -> FCS.
- FCS:
  - crc_en_o=0, so crc_i is stable. crc_i reflects the last byte because the CRC register updated one edge after the final crc_en_o.
  - Byte k (k=0..3) bit i = ~crc_i[31-8k-i]. Byte 0 = ~{crc_i[24],crc_i[25],...,crc_i[31]} with bit0=~crc_i[31].
  - After 4 transfers -> IFG. frame_done_o pulses in the cycle of the 4th transfer.
- IFG: phy_valid_o=0. Counts cycles with phy_ready_i=1; after IFG_BYTES such cycles -> IDLE. tx_ready_o=0 throughout.
- tx_ready_o=0 in every state except PAY. crc_en_o=0 outside PAY/PAD. crc_start_o=1 only in IDLE.
- A new frame cannot start before IFG completes. tx_valid_i held high through IFG starts PRE on the cycle after IFG->IDLE (one IDLE cycle minimum, guaranteeing a CRC reset).
- PAD_EN=0 or payload >= MIN_LEN: PAD is skipped.
- arst_i mid-frame: immediate return to IDLE with outputs at reset values. The partial frame is abandoned with no FCS.

Test Plan:
- PAD_EN=0, payload ASCII "123456789", phy_ready_i=1 -> output 55x7, D5, 31..39, then FCS 26 39 F4 CB; frame_done_o pulses with CB; then 12 idle cycles and busy_o falls.
- PAD_EN=1, 9-byte payload -> 51 zero pad bytes (60 bytes before FCS); FCS matches software CRC-32 of the padded 60 bytes; total 72 transfers.
- 64-byte payload, PAD_EN=1 -> no PAD bytes; exactly 8+64+4 transfers.
- Random phy_ready_i (50%) and tx_valid_i gaps -> byte sequence identical to the ready=1 run; crc_en_o count equals payload+pad bytes; no byte dropped or duplicated.
- Back-to-back frames, tx_valid_i held high -> at least 12 ready-slots of phy_valid_o=0 plus one IDLE cycle between FCS and the next 0x55; second FCS correct.
- arst_i pulsed during PAY byte 5 -> outputs immediately return to reset values; the next frame's FCS is correct (CRC restarted).

Source files
------------

// File: rtl/iob_eth_tx_framer.sv
// Ethernet TX framer: wraps a payload byte stream with preamble/SFD, optional
// zero padding, a 4-byte FCS taken from an external CRC block, and the IFG.
module iob_eth_tx_framer #(
    parameter bit PAD_EN    = 1'b1,
    parameter int MIN_LEN   = 60,
    parameter int IFG_BYTES = 12,
    parameter int CNT_W     = 11
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic [7:0]  tx_data_i,
    input  logic        tx_valid_i,
    input  logic        tx_last_i,
    output logic        tx_ready_o,
    output logic [7:0]  phy_data_o,
    output logic        phy_valid_o,
    input  logic        phy_ready_i,
    output logic        crc_start_o,
    output logic [7:0]  crc_data_o,
    output logic        crc_en_o,
    input  logic [31:0] crc_i,
    output logic        busy_o,
    output logic        frame_done_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_PAY, S_PAD, S_FCS, S_IFG
    } state_t;

    // One slot counter serves preamble, FCS index and IFG, so size it for the longest.
    localparam int SLOT_MAX = (IFG_BYTES > 7) ? IFG_BYTES : 7;
    localparam int SLOT_W   = $clog2(SLOT_MAX + 1);

    localparam logic [SLOT_W-1:0] PRE_LAST = SLOT_W'(6);
    localparam logic [SLOT_W-1:0] FCS_LAST = SLOT_W'(3);
    localparam logic [SLOT_W-1:0] IFG_LAST = SLOT_W'(IFG_BYTES - 1);
    localparam logic [CNT_W-1:0]  MIN_LEN_C = CNT_W'(MIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [31:0]        fcs_word;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= S_IDLE;
            slot_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
        end
    end

    // FCS goes out as the complemented, bit-reversed CRC register, byte 0 first.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            fcs_word[i] = ~crc_i[31-i];
        end
    end

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign busy_o  = (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        cnt_d        = cnt_q;
        phy_data_o   = 8'h00;
        phy_valid_o  = 1'b0;
        tx_ready_o   = 1'b0;
        crc_start_o  = 1'b0;
        crc_data_o   = 8'h00;
        crc_en_o     = 1'b0;
        frame_done_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                crc_start_o = 1'b1;
                slot_d      = '0;
                if (tx_valid_i) begin
                    state_d = S_PRE;
                end
            end

            S_PRE: begin
                phy_data_o  = 8'h55;
                phy_valid_o = 1'b1;
                if (phy_ready_i) begin
                    if (slot_q == PRE_LAST) begin
                        slot_d  = '0;
                        state_d = S_SFD;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end

            S_SFD: begin
                phy_data_o  = 8'hD5;
                phy_valid_o = 1'b1;
                if (phy_ready_i) begin
                    cnt_d   = '0;
                    state_d = S_PAY;
                end
            end

            // Payload passes straight through; stalls on either side stall both.
            S_PAY: begin
                phy_data_o  = tx_data_i;
                phy_valid_o = tx_valid_i;
                tx_ready_o  = phy_ready_i;
                crc_data_o  = tx_data_i;
                if (tx_valid_i && phy_ready_i) begin
                    crc_en_o = 1'b1;
                    cnt_d    = cnt_inc;
                    if (tx_last_i) begin
                        slot_d = '0;
                        if (PAD_EN && (cnt_inc < MIN_LEN_C)) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                        end
                    end
                end
            end

            S_PAD: begin
                phy_valid_o = 1'b1;
                if (phy_ready_i) begin
                    crc_en_o = 1'b1;
                    cnt_d    = cnt_inc;
                    if (cnt_inc >= MIN_LEN_C) begin
                        state_d = S_FCS;
                    end
                end
            end

            S_FCS: begin
                phy_data_o  = fcs_word[{slot_q[1:0], 3'b000} +: 8];
                phy_valid_o = 1'b1;
                if (phy_ready_i) begin
                    if (slot_q == FCS_LAST) begin
                        frame_done_o = 1'b1;
                        slot_d       = '0;
                        state_d      = S_IFG;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end

            // Gap is measured in serializer byte slots, not raw clock cycles.
            S_IFG: begin
                if (phy_ready_i) begin
                    if (slot_q == IFG_LAST) begin
                        slot_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        slot_d = slot_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iob_eth_tx_framer.sv
// Bench for iob_eth_tx_framer: a no-pad and a padding instance share one stimulus
// stream (selected by sel); a scoreboard compares every PHY byte against a software frame model.
module tb_iob_eth_tx_framer;

    localparam int MIN_LEN   = 60;
    localparam int IFG_BYTES = 12;

    logic       clk = 1'b0;
    logic       arst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       phy_ready = 1'b1;
    logic       sel = 1'b0;
    logic       rand_mode = 1'b0;

    always #5 clk = ~clk;

    // Per-instance signals: _n = PAD_EN 0, _p = PAD_EN 1
    logic        tx_ready_n, phy_valid_n, crc_start_n, crc_en_n, busy_n, done_n;
    logic        tx_ready_p, phy_valid_p, crc_start_p, crc_en_p, busy_p, done_p;
    logic [7:0]  phy_data_n, crc_data_n, phy_data_p, crc_data_p;
    logic [31:0] crc_n, crc_p, crc_rn, crc_rp;

    logic        tx_ready_m, phy_valid_m, crc_start_m, crc_en_m, busy_m, done_m;
    logic [7:0]  phy_data_m;

    iob_eth_tx_framer #(.PAD_EN(1'b0), .MIN_LEN(MIN_LEN), .IFG_BYTES(IFG_BYTES), .CNT_W(11)) u_nop (
        .clk_i(clk), .arst_i(arst),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid & ~sel), .tx_last_i(tx_last),
        .tx_ready_o(tx_ready_n),
        .phy_data_o(phy_data_n), .phy_valid_o(phy_valid_n), .phy_ready_i(phy_ready),
        .crc_start_o(crc_start_n), .crc_data_o(crc_data_n), .crc_en_o(crc_en_n),
        .crc_i(crc_n), .busy_o(busy_n), .frame_done_o(done_n)
    );

    iob_eth_tx_framer #(.PAD_EN(1'b1), .MIN_LEN(MIN_LEN), .IFG_BYTES(IFG_BYTES), .CNT_W(11)) u_pad (
        .clk_i(clk), .arst_i(arst),
        .tx_data_i(tx_data), .tx_valid_i(tx_valid & sel), .tx_last_i(tx_last),
        .tx_ready_o(tx_ready_p),
        .phy_data_o(phy_data_p), .phy_valid_o(phy_valid_p), .phy_ready_i(phy_ready),
        .crc_start_o(crc_start_p), .crc_data_o(crc_data_p), .crc_en_o(crc_en_p),
        .crc_i(crc_p), .busy_o(busy_p), .frame_done_o(done_p)
    );

    assign tx_ready_m  = sel ? tx_ready_p  : tx_ready_n;
    assign phy_valid_m = sel ? phy_valid_p : phy_valid_n;
    assign phy_data_m  = sel ? phy_data_p  : phy_data_n;
    assign crc_start_m = sel ? crc_start_p : crc_start_n;
    assign crc_en_m    = sel ? crc_en_p    : crc_en_n;
    assign busy_m      = sel ? busy_p      : busy_n;
    assign done_m      = sel ? done_p      : done_n;

    // Reflected CRC-32 (poly 0xEDB88320), one byte per call
    function automatic logic [31:0] crc_step(input logic [31:0] r, input logic [7:0] d);
        logic [31:0] c;
        c = r ^ {24'h0, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bitrev32(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 32; i++) y[i] = x[31-i];
        return y;
    endfunction

    // Model of iob_eth_crc: register seen MSB-first on crc_o
    always @(posedge clk) begin
        if (crc_start_n) crc_rn <= 32'hFFFFFFFF;
        else if (crc_en_n) crc_rn <= crc_step(crc_rn, crc_data_n);
        if (crc_start_p) crc_rp <= 32'hFFFFFFFF;
        else if (crc_en_p) crc_rp <= crc_step(crc_rp, crc_data_p);
    end
    assign crc_n = bitrev32(crc_rn);
    assign crc_p = bitrev32(crc_rp);

    always @(posedge clk) begin
        #1;
        phy_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard: {frame_done, byte}
    logic [8:0] exp_q[$];
    logic [7:0] pay_q[$];
    logic [8:0] mon_exp;
    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int crc_en_cnt = 0;
    int done_cnt = 0;
    int gap_slots = 0;
    int idle_cycles = 0;
    int last_gap = -1;
    int last_idle = -1;
    bit after_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!arst) begin
            if (crc_en_m) crc_en_cnt++;
            if (after_done && !phy_valid_m) begin
                if (!busy_m) idle_cycles++;
                else if (phy_ready) gap_slots++;
            end
            if (phy_valid_m && phy_ready) begin
                xfer_cnt++;
                if (after_done) begin
                    last_gap   = gap_slots;
                    last_idle  = idle_cycles;
                    after_done = 1'b0;
                end
                if (exp_q.size() == 0) begin
                    check("phy_unexpected_byte", {23'h0, done_m, phy_data_m}, 32'h1FF);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("phy_byte", {23'h0, done_m, phy_data_m}, {23'h0, mon_exp});
                end
                if (done_m) begin
                    done_cnt++;
                    after_done  = 1'b1;
                    gap_slots   = 0;
                    idle_cycles = 0;
                end
            end else if (done_m) begin
                check("done_without_transfer", 32'(done_m), 32'd0);
            end
        end
    end

    task automatic push_expected(input bit pad);
        logic [7:0]  fr[$];
        logic [31:0] r;
        fr = pay_q;
        if (pad) while (fr.size() < MIN_LEN) fr.push_back(8'h00);
        r = 32'hFFFFFFFF;
        foreach (fr[i]) r = crc_step(r, fr[i]);
        r = ~r;
        repeat (7) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (fr[i]) exp_q.push_back({1'b0, fr[i]});
        for (int k = 0; k < 4; k++) exp_q.push_back({k == 3, r[8*k +: 8]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phy_valid"}, 32'(phy_valid_m), 32'd0);
        check({tag, "_tx_ready"},  32'(tx_ready_m),  32'd0);
        check({tag, "_crc_en"},    32'(crc_en_m),    32'd0);
        check({tag, "_busy"},      32'(busy_m),      32'd0);
        check({tag, "_done"},      32'(done_m),      32'd0);
        check({tag, "_crc_start"}, 32'(crc_start_m), 32'd1);
    endtask

    // Entered and left at posedge+1
    task automatic drive_frame(input bit hold, input int abort_at, input int max_gap);
        bit acc;
        int budget;
        int g;
        for (int i = 0; i < pay_q.size(); i++) begin
            if (max_gap > 0) begin
                g = $urandom_range(0, max_gap);
                if (g > 0) begin
                    tx_valid = 1'b0;
                    repeat (g) begin @(posedge clk); #1; end
                end
            end
            tx_valid = 1'b1;
            tx_data  = pay_q[i];
            tx_last  = (i == pay_q.size() - 1);
            if (i == abort_at) begin
                #2 arst = 1'b1;
                #1 check_reset_outputs("abort");
                exp_q.delete();
                tx_valid = 1'b0;
                tx_last  = 1'b0;
                @(negedge clk);
                #1 arst = 1'b0;
                @(posedge clk); #1;
                return;
            end
            budget = 2000;
            acc = 1'b0;
            while (!acc && budget > 0) begin
                @(negedge clk);
                acc = tx_ready_m;
                @(posedge clk); #1;
                budget--;
            end
            if (!acc) begin
                check("tx_accept_timeout", 32'd0, 32'd1);
                tx_valid = 1'b0;
                return;
            end
        end
        if (!hold) begin
            tx_valid = 1'b0;
            tx_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int b = 0;
        while (done_cnt < target && b < 5000) begin
            @(posedge clk); #1;
            b++;
        end
        check("frame_done_timeout", 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy_m && cycles < 1000) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("busy_fall_timeout", 32'(busy_m), 32'd0);
    endtask

    task automatic run_pad_frame(input int len, input int max_gap);
        int d0;
        int cyc;
        int body;
        pay_q.delete();
        for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        body = (len < MIN_LEN) ? MIN_LEN : len;
        push_expected(1'b1);
        xfer_cnt   = 0;
        crc_en_cnt = 0;
        d0 = done_cnt;
        drive_frame(1'b0, -1, max_gap);
        wait_done(d0 + 1);
        wait_idle(cyc);
        check("pad_xfer_count", 32'(xfer_cnt), 32'(8 + body + 4));
        check("pad_crc_en_count", 32'(crc_en_cnt), 32'(body));
        check("pad_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int cyc;
        int d0;

        repeat (2) @(posedge clk);
        #1;
        sel = 1'b0;
        check_reset_outputs("rst_nop");
        sel = 1'b1;
        check_reset_outputs("rst_pad");
        arst = 1'b0;
        @(posedge clk); #1;

        // "123456789" without padding: known FCS 26 39 F4 CB
        sel = 1'b0;
        pay_q.delete();
        for (int i = 0; i < 9; i++) pay_q.push_back(8'(8'h31 + i));
        repeat (7) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        foreach (pay_q[i]) exp_q.push_back({1'b0, pay_q[i]});
        exp_q.push_back({1'b0, 8'h26});
        exp_q.push_back({1'b0, 8'h39});
        exp_q.push_back({1'b0, 8'hF4});
        exp_q.push_back({1'b1, 8'hCB});
        xfer_cnt   = 0;
        crc_en_cnt = 0;
        drive_frame(1'b0, -1, 0);
        wait_done(1);
        wait_idle(cyc);
        check("nop_ifg_cycles", 32'(cyc), 32'(IFG_BYTES));
        check("nop_xfer_count", 32'(xfer_cnt), 32'd21);
        check("nop_crc_en_count", 32'(crc_en_cnt), 32'd9);
        check("nop_queue_empty", 32'(exp_q.size()), 32'd0);

        // Same payload with padding to 60 bytes
        sel = 1'b1;
        push_expected(1'b1);
        xfer_cnt   = 0;
        crc_en_cnt = 0;
        d0 = done_cnt;
        drive_frame(1'b0, -1, 0);
        wait_done(d0 + 1);
        wait_idle(cyc);
        check("pad9_ifg_cycles", 32'(cyc), 32'(IFG_BYTES));
        check("pad9_xfer_count", 32'(xfer_cnt), 32'd72);
        check("pad9_crc_en_count", 32'(crc_en_cnt), 32'd60);

        // Length boundaries around MIN_LEN, and a long frame with no padding
        run_pad_frame(64, 0);
        run_pad_frame(59, 0);
        run_pad_frame(60, 0);

        // Random serializer backpressure and source gaps
        rand_mode = 1'b1;
        run_pad_frame(20, 3);
        run_pad_frame(61, 2);
        rand_mode = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frames with tx_valid held high across the gap
        pay_q.delete();
        for (int i = 0; i < 10; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        push_expected(1'b1);
        d0 = done_cnt;
        last_gap  = -1;
        last_idle = -1;
        drive_frame(1'b1, -1, 0);
        pay_q.delete();
        for (int i = 0; i < 15; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        push_expected(1'b1);
        drive_frame(1'b0, -1, 0);
        wait_done(d0 + 2);
        wait_idle(cyc);
        check("b2b_gap_slots", 32'(last_gap), 32'(IFG_BYTES));
        check("b2b_idle_cycles", 32'(last_idle), 32'd1);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset during payload byte 5, then a clean frame
        pay_q.delete();
        for (int i = 0; i < 20; i++) pay_q.push_back(8'($urandom_range(0, 255)));
        push_expected(1'b1);
        drive_frame(1'b0, 5, 0);
        repeat (2) @(posedge clk);
        #1;
        run_pad_frame(12, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
